// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared types and reset defaults for the serial sequence-detect
//            run controller (seq_det_ctrl) and its matcher.
// Contents : state_t         - run-controller state encoding
//            DEFAULT_PATTERN - pattern loaded at reset (LSB-aligned)
//            DEFAULT_LEN     - pattern length loaded at reset
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;
  localparam int         DEFAULT_LEN     = 4;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_matcher.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_matcher
// Purpose  : Serial history shift register with fill tracking and a
//            length-masked pattern compare. The match output is combinational
//            and reflects the history *after* the bit presented this cycle is
//            shifted in, so the controller can register it on the same edge.
// Ports    : clk      in  clock
//            rst_n    in  asynchronous active-low reset
//            clear    in  clear history and fill (start of a run)
//            shift_en in  shift bit_in into the history this cycle
//            bit_in   in  serial bit
//            pattern  in  PAT_W pattern, bit [len-1] is the first bit received
//            len      in  LEN_W active pattern length (1..PAT_W)
//            overlap  in  1 = keep fill after a match, 0 = restart qualification
//            match    out combinational match for this cycle's shifted value
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_matcher #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;

  always_comb begin
    hist_next = {hist[PAT_W-2:0], bit_in};
    // fill counts qualified history bits and saturates at the register depth
    fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match = shift_en && (fill_next >= len) &&
            ((hist_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_next;
      // Non-overlapping mode keeps the old bits but disqualifies them, so the
      // next match needs a full fresh pattern.
      fill <= (match && !overlap) ? '0 : fill_next;
    end
  end

endmodule : seq_det_matcher
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Purpose  : Run controller for serial pattern detection. Holds a
//            programmable pattern, arms/disarms detection runs, counts
//            matches and ends a run on target count, abort or timeout.
// Macro    : SEQ_DET_TIMEOUT_EN - when defined, enables the inactivity
//            timeout (cfg_timeout, timed_out). When undefined, cfg_timeout is
//            ignored and timed_out is tied low; the port list is unchanged.
// Ports    : clk, rst_n         clock, asynchronous active-low reset
//            cfg_we             load config (honoured in IDLE/DONE, valid len)
//            cfg_pattern/len    pattern and its length (1..PAT_W)
//            cfg_overlap        overlapping matches when 1
//            cfg_target         matches ending a run, 0 = unlimited
//            cfg_timeout        max RUN cycles without a match, 0 = disabled
//            start/abort        1-cycle run control strobes (abort wins)
//            in_valid/in        serial input stream
//            busy/done          state == RUN / state == DONE
//            match_pulse        1-cycle pulse per match
//            match_count        saturating match count for current/last run
//            timed_out          run ended by timeout (valid while done)
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 4,
  parameter  int CNT_W = 8,
  parameter  int TO_W  = 16,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             timed_out
);

  localparam int RST_LEN = (DEFAULT_LEN > PAT_W) ? PAT_W : DEFAULT_LEN;

  state_t           state;
  state_t           state_next;

  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic             overlap_q;
  logic [CNT_W-1:0] target_q;

  logic             cfg_ok;
  logic             run_enter;
  logic             in_run;
  logic             shift_en;
  logic             match;
  logic [CNT_W:0]   count_inc;
  logic             target_hit;
  logic             timeout_hit;

  // ------------------------------------------------------------------------
  // Control decode
  // ------------------------------------------------------------------------
  assign cfg_ok    = cfg_we && (state != ST_RUN) &&
                     (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign run_enter = (state != ST_RUN) && start && !abort;
  // An abort edge in RUN is treated as if the run had already ended: no
  // shift, no match, no count.
  assign in_run    = (state == ST_RUN) && !abort;
  assign shift_en  = in_run && in_valid;

  // Extra bit keeps a saturated count from aliasing onto a small target.
  assign count_inc  = {1'b0, match_count} + (CNT_W+1)'(1);
  assign target_hit = match && (target_q != '0) &&
                      (count_inc == {1'b0, target_q});

  // ------------------------------------------------------------------------
  // Configuration registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= PAT_W'(DEFAULT_PATTERN);
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= 1'b1;
      target_q  <= CNT_W'(1);
    end else if (cfg_ok) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      target_q  <= cfg_target;
    end
  end

  // ------------------------------------------------------------------------
  // Matcher
  // ------------------------------------------------------------------------
  seq_det_matcher #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_matcher (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (run_enter),
    .shift_en (shift_en),
    .bit_in   (in),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .match    (match)
  );

  // ------------------------------------------------------------------------
  // Optional inactivity timeout
  // ------------------------------------------------------------------------
`ifdef SEQ_DET_TIMEOUT_EN
  logic [TO_W-1:0] timeout_q;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= '0;
    end else if (cfg_ok) begin
      timeout_q <= cfg_timeout;
    end
  end

  // A match in the expiry cycle wins: the counter restarts instead.
  assign timeout_hit = in_run && (timeout_q != '0) && !match &&
                       (to_cnt == timeout_q - TO_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (run_enter) begin
        to_cnt <= '0;
      end else if (in_run) begin
        to_cnt <= match ? '0 : to_cnt + TO_W'(1);
      end

      if (run_enter) begin
        timed_out <= 1'b0;
      end else if (timeout_hit) begin
        timed_out <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^cfg_timeout;
  assign timeout_hit    = 1'b0;
  assign timed_out      = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Run FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (run_enter) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                          state_next = ST_IDLE;
        else if (target_hit || timeout_hit) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (abort)          state_next = ST_IDLE;
        else if (run_enter) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Match pulse and saturating counter
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= in_run && match;
      if (run_enter) begin
        match_count <= '0;
      end else if (in_run && match && (match_count != '1)) begin
        match_count <= count_inc[CNT_W-1:0];
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule : seq_det_ctrl
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Purpose  : Directed self-checking bench for seq_det_ctrl. Expected values
//            are hand-computed from the pattern/stream of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_pattern;
  logic [2:0]  cfg_len;
  logic        cfg_overlap;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_timeout;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in;
  logic        busy;
  logic        done;
  logic        match_pulse;
  logic [7:0]  match_count;
  logic        timed_out;

  int checks = 0;
  int errors = 0;
  int pulses;

  seq_det_ctrl #(
    .PAT_W (4),
    .CNT_W (8),
    .TO_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (in),
    .busy        (busy),
    .done        (done),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .timed_out   (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic configure(input logic [3:0] pat, input logic [2:0] len,
                           input logic ov, input logic [7:0] tgt,
                           input logic [15:0] tmo);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_target  = tgt;
    cfg_timeout = tmo;
    tick();
    cfg_we      = 1'b0;
  endtask

  // Sends bits[n-1] first; counts match pulses seen after each bit's edge.
  task automatic stream(input logic [15:0] bits, input int n, output int npulse);
    npulse = 0;
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1;
      in       = bits[i];
      tick();
      if (match_pulse) npulse++;
    end
    in_valid = 1'b0;
    in       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_target = '0; cfg_timeout = '0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_count", match_count, 0);
    check("rst_tmo",   timed_out, 0);

    // Defaults: pattern 1010, len 4, target 1
    do_start();
    check("dflt_busy", busy, 1);
    stream(16'b101, 3, pulses);
    check("dflt_early_pulse", pulses, 0);
    stream(16'b0, 1, pulses);
    check("dflt_pulse", match_pulse, 1);
    check("dflt_count", match_count, 1);
    check("dflt_done",  done, 1);
    check("dflt_busy2", busy, 0);
    tick();
    check("dflt_pulse_1cyc", match_pulse, 0);
    check("dflt_done_held", done, 1);

    // Overlapping, target 0
    configure(4'b1010, 3'd4, 1'b1, 8'd0, 16'd0);
    do_start();
    check("ov_count_clr", match_count, 0);
    stream(16'b1010101010, 10, pulses);
    check("ov_pulses", pulses, 4);
    check("ov_count",  match_count, 4);
    check("ov_busy",   busy, 1);
    do_abort();

    // Non-overlapping, same stream
    configure(4'b1010, 3'd4, 1'b0, 8'd0, 16'd0);
    do_start();
    stream(16'b1010101010, 10, pulses);
    check("nov_pulses", pulses, 2);
    check("nov_count",  match_count, 2);
    do_abort();

    // Pattern 110, len 3, target 2; reconfig during RUN ignored
    configure(4'b0110, 3'd3, 1'b1, 8'd2, 16'd0);
    do_start();
    configure(4'b0010, 3'd2, 1'b1, 8'd1, 16'd0);
    check("runcfg_busy", busy, 1);
    stream(16'b110110, 6, pulses);
    check("p110_pulses", pulses, 2);
    check("p110_count",  match_count, 2);
    check("p110_done",   done, 1);

    // Abort from DONE, then start+abort together in IDLE
    do_abort();
    check("abort_done_done", done, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_done", done, 0);

    // Abort on the edge that would complete the second match
    do_start();
    stream(16'b110, 3, pulses);
    check("ab_first", match_count, 1);
    stream(16'b11, 2, pulses);
    in_valid = 1'b1; in = 1'b0; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("ab_busy",  busy, 0);
    check("ab_done",  done, 0);
    check("ab_pulse", match_pulse, 0);
    check("ab_count", match_count, 1);

    // cfg_len = 0 write ignored: 110/len3/target2 still active
    configure(4'b0000, 3'd0, 1'b0, 8'd5, 16'd0);
    do_start();
    stream(16'b110110, 6, pulses);
    check("len0_pulses", pulses, 2);
    check("len0_done",   done, 1);
    check("len0_count",  match_count, 2);

    // Saturation: len 1 pattern 1, stream of ones
    do_abort();
    configure(4'b0001, 3'd1, 1'b1, 8'd0, 16'd0);
    do_start();
    in_valid = 1'b1; in = 1'b1;
    repeat (300) tick();
    check("sat_count", match_count, 8'hFF);
    check("sat_pulse", match_pulse, 1);
    check("sat_busy",  busy, 1);
    in_valid = 1'b0; in = 1'b0;
    do_abort();

    // Timeout 5 with no input
    configure(4'b1010, 3'd4, 1'b1, 8'd0, 16'd5);
    do_start();
    repeat (4) tick();
    check("tmo_busy4", busy, 1);
    tick();
`ifdef SEQ_DET_TIMEOUT_EN
    check("tmo_done",  done, 1);
    check("tmo_flag",  timed_out, 1);
    check("tmo_busy5", busy, 0);
`else
    check("tmo_busy5", busy, 1);
    check("tmo_flag",  timed_out, 0);
`endif
    do_abort();

    // Asynchronous reset mid-run
    do_start();
    stream(16'b1010, 4, pulses);
    check("mr_count_pre", match_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy",  busy, 0);
    check("mr_count", match_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // Config back to defaults: 1010 with target 1 ends the run
    do_start();
    stream(16'b1010, 4, pulses);
    check("mr_dflt_done",  done, 1);
    check("mr_dflt_count", match_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_det_ctrl
`default_nettype wire
